// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time against a word-organised RAM,
// RISC-V SB/SH/SW and LB/LH/LW/LBU/LHU semantics, fixed-latency response.
module data_mem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_store_type,
  input  logic [2:0]        req_load_type,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;

  logic               wr_p0;
  logic [ADDR_W+1:0]  addr_p0;
  logic [DATA_W-1:0]  wdata_p0;
  logic [1:0]         st_type_p0;
  logic [2:0]         ld_type_p0;

  logic [DATA_W-1:0]  mem [2**ADDR_W];
  logic [ADDR_W-1:0]  word_idx;
  logic [1:0]         lane;
  logic               access;
  logic               acc_err;
  logic [3:0]         be;
  logic [DATA_W-1:0]  wdata_al;
  logic [DATA_W-1:0]  rd_word;

  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  function automatic logic store_err(input logic [1:0] t, input logic [1:0] a);
    case (t)
      2'b00:   store_err = 1'b0;
      2'b01:   store_err = a[0];
      2'b10:   store_err = |a;
      default: store_err = 1'b1;
    endcase
  endfunction

  function automatic logic load_err(input logic [2:0] t, input logic [1:0] a);
    case (t)
      3'b000, 3'b100: load_err = 1'b0;
      3'b001, 3'b101: load_err = a[0];
      3'b010:         load_err = |a;
      default:        load_err = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] t, input logic [1:0] a);
    case (t)
      2'b00:   store_be = 4'b0001 << a;
      2'b01:   store_be = a[1] ? 4'b1100 : 4'b0011;
      2'b10:   store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_align(input logic [1:0] t,
                                                    input logic [DATA_W-1:0] d);
    case (t)
      2'b00:   store_align = {4{d[7:0]}};
      2'b01:   store_align = {2{d[15:0]}};
      default: store_align = d;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] w,
                                                    input logic [2:0] t,
                                                    input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (t)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b100:  load_extend = {24'h0, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b101:  load_extend = {16'h0, h};
      3'b010:  load_extend = w;
      default: load_extend = '0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid)
        cnt <= CNT_W'(LATENCY - 1);
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE:    req_ready = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // p0: request capture at the accept edge
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      wr_p0      <= req_write;
      addr_p0    <= req_addr[ADDR_W+1:0];
      wdata_p0   <= req_wdata;
      st_type_p0 <= req_store_type;
      ld_type_p0 <= req_load_type;
    end
  end

  always_comb begin
    word_idx = addr_p0[ADDR_W+1:2];
    lane     = addr_p0[1:0];
    access   = (state == WAIT) && (cnt == '0);
    acc_err  = wr_p0 ? store_err(st_type_p0, lane) : load_err(ld_type_p0, lane);
    be       = store_be(st_type_p0, lane);
    wdata_al = store_align(st_type_p0, wdata_p0);
    rd_word  = mem[word_idx];
  end

  // p1: RAM access and response registers at the WAIT exit edge
  always_ff @(posedge clk) begin
    if (access && !reset && wr_p0 && !acc_err) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[word_idx][8*i +: 8] <= wdata_al[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (access) begin
      rsp_err   <= acc_err;
      rsp_rdata <= (wr_p0 || acc_err) ? '0 : load_extend(rd_word, ld_type_p0, lane);
    end
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the core's data-memory load/store interface. It accepts one load or store request at a time over a valid/ready handshake and applies the RISC-V store types (SB/SH/SW) and load types (LB/LH/LW/LBU/LHU) against an internal word-organised RAM. After a fixed access latency it returns read data, or an error flag, over a second valid/ready handshake. It is the slave end of the data-memory port that a multi-cycle or pipelined core will drive.

Parameters:
DATA_W, 32, data width in bits; only 32 is supported.
ADDR_W, 9, word-address width; RAM depth is 2**ADDR_W words.
LATENCY, 2, cycles from request accept to response valid; must be at least 1.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_write  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_store_type  input  2  00 = SB, 01 = SH, 10 = SW, 11 = illegal
req_load_type  input  3  funct3 encoding: 000 = LB, 001 = LH, 010 = LW, 100 = LBU, 101 = LHU; all other codes illegal
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts the response
rsp_rdata  output  32  extended load data; 0 for stores and for errors
rsp_err  output  1  misaligned access or illegal type

Behaviour:
- Reset (synchronous, active-high) produces these values:
  - state = IDLE
  - req_ready = 1
  - rsp_valid = 0
  - rsp_rdata = 0
  - rsp_err = 0
  - latency counter = 0
  - RAM contents are not cleared.
- Reset asserted in any state aborts the transaction in flight. A store whose commit edge has not yet occurred is never written.
- FSM states are IDLE, WAIT and RESP.
  - IDLE: req_ready = 1. When req_valid and req_ready are both high at an edge, the responder captures write, addr, wdata and type, loads the counter with LATENCY-1, and moves to WAIT.
  - WAIT: req_ready = 0. If the counter is nonzero it decrements. If the counter is 0, the access is performed, the response registers are loaded, and the state moves to RESP.
  - RESP: rsp_valid = 1 and req_ready = 0. When rsp_valid and rsp_ready are both high at an edge, the state returns to IDLE. rsp_rdata and rsp_err hold stable while rsp_ready is low.
- Latency: if the request is accepted at edge N, rsp_valid is high after edge N+LATENCY.
- No request is accepted in the cycle a response completes. The minimum request-to-request spacing is LATENCY+2 cycles.
- Addressing:
  - Word index = req_addr[ADDR_W+1:2].
  - req_addr[31:ADDR_W+2] is ignored, so addresses wrap modulo the RAM size.
- Stores (commit at the WAIT exit edge, one word write with byte enables):
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; the low byte goes to the lower lane.
  - SW writes all four lanes.
- Loads (RAM read at the WAIT exit edge):
  - LB and LBU select byte addr[1:0].
  - LH and LHU select half addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW returns the full word.
- Error conditions set rsp_err = 1 and rsp_rdata = 0, with no RAM write:
  - SH, LH or LHU with addr[0] = 1.
  - SW or LW with addr[1:0] != 00.
  - Illegal store or load type code.
- A store response returns rsp_rdata = 0 and rsp_err = 0.
- A load and a store never overlap, so there are no read-during-write hazards.

Test Plan:
- SW addr 0x10 wdata 0xDEADBEEF, then LW addr 0x10 -> response is rsp_rdata = 0xDEADBEEF, rsp_err = 0; with LATENCY = 2, rsp_valid rises exactly 2 edges after each accept.
- SW 0x0 to addr 0x20, SB addr 0x23 wdata 0x80, then:
  - LB 0x23 returns 0xFFFFFF80.
  - LBU 0x23 returns 0x00000080.
  - LW 0x20 returns 0x80000000.
- SH addr 0x31 wdata 0x1234 -> rsp_err = 1 and rsp_rdata = 0. A following LW 0x30 returns its prior value (0 after a preceding SW 0).
- SH addr 0x42 wdata 0x8001, then:
  - LH 0x42 returns 0xFFFF8001.
  - LHU 0x42 returns 0x00008001.
  - Load type 011 returns rsp_err = 1.
- Backpressure: hold rsp_ready low for 5 cycles during a response -> rsp_valid stays 1, rsp_rdata stays stable, and req_ready stays 0. After the handshake, req_ready = 1 on the next cycle.
- Abort: SW addr 0x50 wdata 0xAAAAAAAA, with reset asserted one cycle after the accept (LATENCY = 3) -> after reset, LW 0x50 returns the old value and all outputs match their reset values during reset.
